// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file command sequencer.
package regfile_ctrl_pkg;

  localparam int unsigned RegIdxW = 3;
  localparam int unsigned NumRegs = 8;

  typedef enum logic [1:0] {
    OpMovi = 2'b00,
    OpMov  = 2'b01,
    OpAdd  = 2'b10,
    OpAnd  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StReadA,
    StReadB,
    StWrite
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Command sequencer for the 8x16 register file: accepts one command at a time, reads up to two
// source registers on consecutive cycles, then issues a single-cycle write of the result.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned IMMW = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [RegIdxW-1:0] cmd_rd_i,
  input  logic [RegIdxW-1:0] cmd_rs_i,
  input  logic [RegIdxW-1:0] cmd_rt_i,
  input  logic [IMMW-1:0]    cmd_imm_i,
  output logic [RegIdxW-1:0] readnum_o,
  input  logic [N-1:0]       rf_rdata_i,
  output logic [RegIdxW-1:0] writenum_o,
  output logic               write_o,
  output logic [N-1:0]       rf_wdata_o,
  output logic               done_o,
  output logic               zero_o
);

  state_e              state_q;
  op_e                 op_q;
  logic [RegIdxW-1:0]  rd_q;
  logic [RegIdxW-1:0]  rt_q;
  logic [N-1:0]        a_q;
  logic                ready_q;
  logic [RegIdxW-1:0]  readnum_q;
  logic [RegIdxW-1:0]  writenum_q;
  logic                write_q;
  logic                done_q;
  logic [N-1:0]        wdata_q;
  logic                zero_q;

  logic [N-1:0]        imm_ext;
  logic [N-1:0]        alu_res;

  // Sign-extended immediate and the two-operand result; B is taken straight from the read port
  // so the result is ready at the edge that leaves READB.
  always_comb begin
    imm_ext = {{(N - IMMW){cmd_imm_i[IMMW-1]}}, cmd_imm_i};
    alu_res = (op_q == OpAnd) ? (a_q & rf_rdata_i) : (a_q + rf_rdata_i);
  end

  // Sequencer FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      op_q       <= OpMovi;
      rd_q       <= '0;
      rt_q       <= '0;
      a_q        <= '0;
      ready_q    <= 1'b1;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      wdata_q    <= '0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i && ready_q) begin
            op_q    <= op_e'(cmd_op_i);
            rd_q    <= cmd_rd_i;
            rt_q    <= cmd_rt_i;
            ready_q <= 1'b0;
            if (op_e'(cmd_op_i) == OpMovi) begin
              state_q    <= StWrite;
              write_q    <= 1'b1;
              done_q     <= 1'b1;
              writenum_q <= cmd_rd_i;
              wdata_q    <= imm_ext;
            end else begin
              state_q   <= StReadA;
              readnum_q <= cmd_rs_i;
            end
          end
        end
        StReadA: begin
          a_q <= rf_rdata_i;
          if (op_q == OpMov) begin
            state_q    <= StWrite;
            readnum_q  <= '0;
            write_q    <= 1'b1;
            done_q     <= 1'b1;
            writenum_q <= rd_q;
            wdata_q    <= rf_rdata_i;
          end else begin
            state_q   <= StReadB;
            readnum_q <= rt_q;
          end
        end
        StReadB: begin
          state_q    <= StWrite;
          readnum_q  <= '0;
          write_q    <= 1'b1;
          done_q     <= 1'b1;
          writenum_q <= rd_q;
          wdata_q    <= alu_res;
        end
        StWrite: begin
          state_q <= StIdle;
          write_q <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          zero_q  <= (wdata_q == '0);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign readnum_o   = readnum_q;
  assign writenum_o  = writenum_q;
  assign write_o     = write_q;
  assign rf_wdata_o  = wdata_q;
  assign done_o      = done_q;
  assign zero_o      = zero_q;

endmodule
